// File: rtl/mem_pkg.sv
// Shared constants and types for the pipelined main-memory model.
// Optional feature macro: MEM_RAW_FORWARD_EN (write data forwarded into in-flight reads).
package mem_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 16;
  localparam int unsigned MEM_DATA_WIDTH = 16;
  localparam int unsigned MEM_LATENCY    = 4;
  localparam int unsigned MEM_INFLIGHT_W = 4;

  // One read-pipeline stage at the default widths: valid flag, word index, data word.
  typedef struct packed {
    logic                      valid;
    logic [MEM_ADDR_WIDTH-2:0] idx;
    logic [MEM_DATA_WIDTH-1:0] data;
  } mem_stage_t;

endpackage

// File: rtl/mem_array_1p.sv
// Single-port word array: combinational read of the addressed word (captured
// by the caller at the accepting edge) and write at the rising edge.
// Contents are deliberately not reset.
module mem_array_1p #(
  parameter int unsigned IDX_WIDTH  = 15,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**IDX_WIDTH];

  assign rd_data = mem[idx];

  // Store the write word at the edge on which the write is accepted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end

endmodule

// File: rtl/pipelined_main_mem.sv
// Pipelined main-memory model serving the cache fill FSM: one request per
// cycle, reads return after a fixed LATENCY with data_valid.
// Optional feature macro: MEM_RAW_FORWARD_EN -- when defined, a write updates
// the data of every in-flight read of the same word.
module pipelined_main_mem
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned LATENCY    = MEM_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      wr,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_valid,
  output logic                      busy,
  output logic [MEM_INFLIGHT_W-1:0] inflight
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 1;

  // Same layout as mem_stage_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  valid;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  logic [IDX_W-1:0]          req_idx;
  logic                      rd_accept;
  logic                      wr_accept;
  logic                      retire;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic [MEM_INFLIGHT_W-1:0] count;
  stage_t                    stages     [LATENCY];
  stage_t                    stages_nxt [LATENCY];
  logic                      unused_addr_lsb;

  assign req_idx         = addr[ADDR_WIDTH-1:1];
  assign unused_addr_lsb = addr[0];
  assign rd_accept       = enable & ~wr;
  assign wr_accept       = enable & wr;
  assign retire          = stages[LATENCY-1].valid;

  mem_array_1p #(
    .IDX_WIDTH  (IDX_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_accept),
    .idx     (req_idx),
    .wr_data (data_in),
    .rd_data (rd_data)
  );

  // Next pipeline contents: new read (or bubble) into stage 1, others shift by one.
  always_comb begin
    stages_nxt    = '{default: '0};
    stages_nxt[0] = '{valid: rd_accept, idx: req_idx, data: rd_data};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stages_nxt[i] = stages[i-1];
`ifdef MEM_RAW_FORWARD_EN
      // Forwarding is applied to the entry as it shifts, so the stage that
      // holds the word after this edge carries the freshly written data.
      if (wr_accept && stages[i-1].valid && (stages[i-1].idx == req_idx)) begin
        stages_nxt[i].data = data_in;
      end
`endif
    end
  end

  // Advance the stage pipeline every cycle; reset drops all in-flight reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stages <= '{default: '0};
    end else begin
      stages <= stages_nxt;
    end
  end

  // Occupancy: count up on accepted read, down on retirement, hold if both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({rd_accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data_valid = stages[LATENCY-1].valid;
  assign data_out   = stages[LATENCY-1].valid ? stages[LATENCY-1].data : '0;
  assign inflight   = count;
  assign busy       = (count != '0);

endmodule
